// File: rtl/fifo_drain_display_if.sv
// Bundle between the drain/display block and its FIFO, pause control and board outputs.
// master = drain block, slave = FIFO/board side.
interface fifo_drain_display_if #(
  parameter int CNT_W = 8
);
  logic             empty;
  logic [3:0]       fifo_out;
  logic             pause;
  logic             pop;
  logic [6:0]       seg;
  logic             valid;
  logic             busy;
  logic [CNT_W-1:0] cnt;

  modport master (
    input  empty, fifo_out, pause,
    output pop, seg, valid, busy, cnt
  );

  modport slave (
    output empty, fifo_out, pause,
    input  pop, seg, valid, busy, cnt
  );
endinterface

// File: rtl/fifo_drain_display.sv
// Pops a 4-bit FIFO one entry at a time and shows each nibble on a 7-segment display for HOLD cycles.
// HOLD must be 1..255. Define DRAIN_HEX_EN for full A..F glyphs; otherwise A..F show a dash.
module fifo_drain_display #(
  parameter int HOLD  = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_drain_display_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LATCH = 2'd2,
    SHOW  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_q,  hold_d;
  logic [3:0]       disp_q,  disp_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
`ifdef DRAIN_HEX_EN
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
`else
      default: s = 7'h40;
`endif
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      disp_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    disp_d  = disp_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!bus.empty) state_d = POP;
      end
      POP: begin
        state_d = LATCH;
      end
      LATCH: begin
        // FIFO read data is registered, so it is valid only now, one cycle after the pop pulse.
        disp_d  = bus.fifo_out;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        hold_d  = HOLD_LOAD;
        state_d = SHOW;
      end
      SHOW: begin
        if (bus.pause) begin
          hold_d = hold_q;
        end else if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          state_d = bus.empty ? IDLE : POP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Blank until the first value is latched; afterwards the last value stays lit through IDLE.
  assign bus.seg   = valid_q ? decode(disp_q) : 7'h00;
  assign bus.valid = valid_q;
  assign bus.pop   = (state_q == POP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_drain_display.sv
// Directed plus randomized bench for fifo_drain_display against a cycle-accounting model built
// on a queue-based FIFO emulation.
module tb_fifo_drain_display;
  localparam int HOLD  = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_drain_display_if #(.CNT_W(CNT_W)) ifc ();

  fifo_drain_display #(.HOLD(HOLD), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop = -100;
  logic [3:0] fifo_q[$];
  int pop_cyc[$];
  logic [6:0] shown_q[$];

  // Model: unpaused SHOW cycles left for the value on display, plus pop/latch pipeline flags.
  bit               m_pop, m_latch, m_valid;
  int               m_left;
  logic [3:0]       m_pending;
  logic [6:0]       m_seg;
  logic [CNT_W-1:0] m_cnt;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef DRAIN_HEX_EN
    return t[v];
`else
    return (v > 4'd9) ? 7'h40 : t[v];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pop = 0; m_latch = 0; m_valid = 0; m_left = 0; m_seg = 7'h00; m_cnt = '0;
  endtask

  task automatic model_advance();
    bit next_pop;
    bit next_latch;
    next_pop   = 0;
    next_latch = 0;
    if (m_pop) begin
      next_latch = 1;
    end else if (m_latch) begin
      m_seg   = seg_of(m_pending);
      m_valid = 1;
      m_cnt   = m_cnt + 1'b1;
      m_left  = HOLD;
    end else if (m_left > 0) begin
      if (!ifc.pause) begin
        m_left--;
        if (m_left == 0) next_pop = !ifc.empty;
      end
    end else begin
      next_pop = !ifc.empty;
    end
    m_pop   = next_pop;
    m_latch = next_latch;
  endtask

  task automatic step();
    if (!rst) model_reset(); else model_advance();
    @(negedge clk);
    cyc++;
    chk("pop",   ifc.pop,   m_pop);
    chk("valid", ifc.valid, m_valid);
    chk("busy",  ifc.busy,  (m_pop || m_latch || m_left > 0));
    chk("seg",   ifc.seg,   m_seg);
    chk("cnt",   ifc.cnt,   m_cnt);
    if (cyc == last_pop + 2) shown_q.push_back(ifc.seg);
    if (ifc.pop) begin
      pop_cyc.push_back(cyc);
      last_pop = cyc;
      if (fifo_q.size() > 0) ifc.fifo_out = fifo_q.pop_front();
    end
    if (m_pop) m_pending = ifc.fifo_out;
    ifc.empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
    ifc.empty = 1'b0;
  endtask

  task automatic wait_pop(input int lim, input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!ifc.pop && k < lim);
    chk(tag, ifc.pop, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n0, busy_cnt, vis, k;
    ifc.empty = 1'b1; ifc.fifo_out = 4'h0; ifc.pause = 1'b0;
    model_reset();

    // Reset held, then 10 cycles with the FIFO empty.
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    chk("idle_no_pop", pop_cyc.size(), 0);
    chk("idle_seg", ifc.seg, 7'h00);

    // Single entry 2.
    push(4'h2);
    t0 = cyc;
    wait_pop(10, "t2_pop_wait");
    chk("t2_pop_latency", pop_cyc[$] - t0, 1);
    vis = 0;
    repeat (6) begin
      step();
      if (ifc.busy && ifc.valid && ifc.seg == 7'h5B) vis++;
    end
    chk("t2_visible_cycles", vis, HOLD);
    chk("t2_cnt", ifc.cnt, 1);
    chk("t2_back_idle", ifc.busy, 1'b0);

    // Three queued entries, back to back.
    n0 = pop_cyc.size();
    shown_q.delete();
    push(4'h2); push(4'h3); push(4'h5);
    repeat (3 * (HOLD + 2) + 3) step();
    chk("t3_pop_count", pop_cyc.size() - n0, 3);
    if (pop_cyc.size() >= n0 + 3) begin
      chk("t3_gap1", pop_cyc[n0+1] - pop_cyc[n0], HOLD + 2);
      chk("t3_gap2", pop_cyc[n0+2] - pop_cyc[n0+1], HOLD + 2);
    end
    chk("t3_shown_n", shown_q.size(), 3);
    if (shown_q.size() >= 3) begin
      chk("t3_seg0", shown_q[0], 7'h5B);
      chk("t3_seg1", shown_q[1], 7'h4F);
      chk("t3_seg2", shown_q[2], 7'h6D);
    end
    chk("t3_cnt", ifc.cnt, 4);

    // Pause for 5 cycles while 8 is shown; a second entry waits behind it.
    push(4'h8); push(4'h1);
    wait_pop(20, "t4_pop_wait");
    t0 = cyc;
    repeat (2) step();
    chk("t4_seg", ifc.seg, 7'h7F);
    ifc.pause = 1'b1;
    n0 = pop_cyc.size();
    repeat (5) step();
    ifc.pause = 1'b0;
    chk("t4_no_pop_paused", pop_cyc.size() - n0, 0);
    wait_pop(20, "t4_next_pop_wait");
    chk("t4_gap", cyc - t0, HOLD + 5 + 2);
    repeat (HOLD + 3) step();

    // Value A: glyph depends on the build.
    push(4'hA);
    wait_pop(20, "t5_pop_wait");
    repeat (2) step();
`ifdef DRAIN_HEX_EN
    chk("t5_seg_A", ifc.seg, 7'h77);
`else
    chk("t5_seg_A", ifc.seg, 7'h40);
`endif
    chk("t5_valid", ifc.valid, 1'b1);
    repeat (HOLD + 2) step();

    // Asynchronous reset while pop is high.
    push(4'h1); push(4'h2); push(4'h3);
    wait_pop(20, "t6_pop_wait");
    #2 rst = 1'b0;
    #1;
    chk("t6_pop_async", ifc.pop, 1'b0);
    chk("t6_valid_async", ifc.valid, 1'b0);
    chk("t6_busy_async", ifc.busy, 1'b0);
    chk("t6_seg_async", ifc.seg, 7'h00);
    chk("t6_cnt_async", ifc.cnt, 0);
    model_reset();
    repeat (2) step();
    rst = 1'b1;
    t0 = cyc;
    wait_pop(10, "t6_resume_wait");
    chk("t6_resume_latency", cyc - t0, 1);
    repeat (2) step();
    chk("t6_seg_after", ifc.seg, 7'h5B);
    chk("t6_cnt_after", ifc.cnt, 1);

    // Randomized traffic with pauses.
    busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      ifc.pause = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) push(4'($urandom_range(0, 15)));
      step();
      if (ifc.busy) busy_cnt++;
    end
    ifc.pause = 1'b0;
    k = 0;
    while ((fifo_q.size() > 0 || m_pop || m_latch || m_left > 0) && k < 3000) begin
      step();
      k++;
    end
    chk("rand_drained", fifo_q.size(), 0);
    chk("rand_idle", ifc.busy, 1'b0);
    chk("rand_was_busy", (busy_cnt > 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
